// File: rtl/mem_access_ctrl.sv
// LC-3 memory access controller: MAR/MDR, req/ack access with timeout.
// Define MEM_MMIO_EN to service KBSR/KBDR/DSR/DDR locally.
module mem_access_ctrl #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] marIn,
  input  logic        ldMAR,
  input  logic [15:0] busIn,
  input  logic        ldMDR,
  input  logic        memEn,
  input  logic        rw,
  output logic [15:0] mdrOut,
  output logic        R,
  output logic        accErr,
  output logic [15:0] memAddr,
  output logic [15:0] memWData,
  input  logic [15:0] memRData,
  output logic        memReq,
  output logic        memWe,
  input  logic        memAck,
  input  logic        kbdStrobe,
  input  logic [7:0]  kbdData,
  input  logic        dspReady,
  output logic        ddrStrobe,
  output logic [7:0]  ddrData
);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    DONE
  } state_e;

  localparam logic [16:0] TO_LIM = 17'(TIMEOUT);

  state_e      state_q, state_d;
  logic [15:0] mar_q, mar_d;
  logic [15:0] mdr_q, mdr_d;
  logic [15:0] cnt_q, cnt_d;
  logic        rw_q, rw_d;
  logic        err_q, err_d;
  logic        r_q;
  logic        req_q;
  logic        we_q;

  logic [15:0] eff_addr;
  logic [15:0] eff_mdr;
  logic        mmio_hit;
  logic [15:0] mmio_rdata;

  // A same-cycle ldMAR/ldMDR feeds the access started by memEn.
  assign eff_addr = ldMAR ? marIn : mar_q;
  assign eff_mdr  = ldMDR ? busIn : mdr_q;

`ifdef MEM_MMIO_EN
  logic       kb_rdy_q;
  logic       kb_ie_q;
  logic [7:0] kbdr_q;
  logic       ddr_stb_q;
  logic [7:0] ddr_q;
  logic       is_kbsr, is_kbdr, is_dsr, is_ddr;
  logic       mmio_go;

  always_comb begin
    is_kbsr    = (eff_addr == 16'hFE00);
    is_kbdr    = (eff_addr == 16'hFE02);
    is_dsr     = (eff_addr == 16'hFE04);
    is_ddr     = (eff_addr == 16'hFE06);
    mmio_hit   = is_kbsr | is_kbdr | is_dsr | is_ddr;
    mmio_go    = (state_q == IDLE) && memEn && mmio_hit;
    mmio_rdata = '0;
    unique case (1'b1)
      is_kbsr: mmio_rdata = {kb_rdy_q, kb_ie_q, 14'h0};
      is_kbdr: mmio_rdata = {8'h0, kbdr_q};
      is_dsr:  mmio_rdata = {dspReady, 15'h0};
      default: mmio_rdata = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      kb_rdy_q  <= 1'b0;
      kb_ie_q   <= 1'b0;
      kbdr_q    <= '0;
      ddr_stb_q <= 1'b0;
      ddr_q     <= '0;
    end else begin
      // A new keystroke beats the clear from a KBDR read.
      if (kbdStrobe) begin
        kb_rdy_q <= 1'b1;
        kbdr_q   <= kbdData;
      end else if (mmio_go && !rw && is_kbdr) begin
        kb_rdy_q <= 1'b0;
      end
      if (mmio_go && rw && is_kbsr) begin
        kb_ie_q <= eff_mdr[14];
      end
      ddr_stb_q <= mmio_go && rw && is_ddr;
      if (mmio_go && rw && is_ddr) begin
        ddr_q <= eff_mdr[7:0];
      end
    end
  end

  assign ddrStrobe = ddr_stb_q;
  assign ddrData   = ddr_q;
`else
  logic unused_mmio;

  assign mmio_hit    = 1'b0;
  assign mmio_rdata  = '0;
  assign ddrStrobe   = 1'b0;
  assign ddrData     = '0;
  assign unused_mmio = ^{kbdStrobe, kbdData, dspReady};
`endif

  always_comb begin
    state_d = state_q;
    mar_d   = mar_q;
    mdr_d   = mdr_q;
    cnt_d   = cnt_q;
    rw_d    = rw_q;
    err_d   = err_q;
    unique case (state_q)
      IDLE: begin
        mar_d = eff_addr;
        mdr_d = eff_mdr;
        if (memEn) begin
          rw_d = rw;
          if (mmio_hit) begin
            state_d = DONE;
            if (!rw) begin
              mdr_d = mmio_rdata;
            end
          end else begin
            state_d = REQ;
          end
        end
      end
      REQ: begin
        if (memAck) begin
          state_d = DONE;
          if (!rw_q) begin
            mdr_d = memRData;
          end
        end else if ({1'b0, cnt_q} + 17'd1 == TO_LIM) begin
          state_d = DONE;
          err_d   = 1'b1;
          if (!rw_q) begin
            mdr_d = '0;
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      DONE: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      mar_q   <= '0;
      mdr_q   <= '0;
      cnt_q   <= '0;
      rw_q    <= 1'b0;
      err_q   <= 1'b0;
      r_q     <= 1'b0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      mar_q   <= mar_d;
      mdr_q   <= mdr_d;
      cnt_q   <= cnt_d;
      rw_q    <= rw_d;
      err_q   <= err_d;
      r_q     <= (state_q == DONE);
      req_q   <= (state_d == REQ);
      we_q    <= (state_d == REQ) && rw_d;
    end
  end

  assign mdrOut   = mdr_q;
  assign memAddr  = mar_q;
  assign memWData = mdr_q;
  assign R        = r_q;
  assign accErr   = err_q;
  assign memReq   = req_q;
  assign memWe    = we_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Randomized self-checking bench for mem_access_ctrl.
// Reference model tracks MAR/MDR/accErr and expected handshake timing.
module tb_mem_access_ctrl;

  localparam int TO = 4;
`ifdef MEM_MMIO_EN
  localparam bit MMIO = 1'b1;
`else
  localparam bit MMIO = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] marIn = '0;
  logic        ldMAR = 1'b0;
  logic [15:0] busIn = '0;
  logic        ldMDR = 1'b0;
  logic        memEn = 1'b0;
  logic        rw = 1'b0;
  logic [15:0] mdrOut;
  logic        R;
  logic        accErr;
  logic [15:0] memAddr;
  logic [15:0] memWData;
  logic [15:0] memRData = '0;
  logic        memReq;
  logic        memWe;
  logic        memAck = 1'b0;
  logic        kbdStrobe = 1'b0;
  logic [7:0]  kbdData = '0;
  logic        dspReady = 1'b0;
  logic        ddrStrobe;
  logic [7:0]  ddrData;

  int checks = 0;
  int errors = 0;

  logic [15:0] mar_m = '0;
  logic [15:0] mdr_m = '0;
  bit          err_m = 1'b0;

  always #5 clk = ~clk;

  mem_access_ctrl #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .marIn(marIn), .ldMAR(ldMAR),
    .busIn(busIn), .ldMDR(ldMDR),
    .memEn(memEn), .rw(rw),
    .mdrOut(mdrOut), .R(R), .accErr(accErr),
    .memAddr(memAddr), .memWData(memWData),
    .memRData(memRData), .memReq(memReq),
    .memWe(memWe), .memAck(memAck),
    .kbdStrobe(kbdStrobe), .kbdData(kbdData),
    .dspReady(dspReady), .ddrStrobe(ddrStrobe),
    .ddrData(ddrData)
  );

  function automatic bit is_mmio(input logic [15:0] a);
    return MMIO && (a == 16'hFE00 || a == 16'hFE02 ||
                    a == 16'hFE04 || a == 16'hFE06);
  endfunction

  // One access; delay = REQ cycles before ack (>= TO means never).
  task automatic access(input string nm, input logic [15:0] addr,
                        input bit wr, input logic [15:0] wdata,
                        input int delay, input logic [15:0] rdata,
                        input bit poke, input logic [15:0] mmio_rd);
    bit mm;
    int exp_reqc, reqc, rc, rt, dc, bad, exp_dc;
    logic [7:0] dd;
    mm = is_mmio(addr);
    exp_reqc = mm ? 0 : (delay < TO ? delay + 1 : TO);
    exp_dc = (mm && wr && addr == 16'hFE06) ? 1 : 0;
    mar_m = addr;
    if (wr) mdr_m = wdata;
    else if (mm) mdr_m = mmio_rd;
    else if (delay >= TO) mdr_m = '0;
    else mdr_m = rdata;
    if (!mm && delay >= TO) err_m = 1'b1;
    reqc = 0; rc = 0; rt = -1; dc = 0; bad = 0; dd = '0;
    marIn = addr; ldMAR = 1'b1;
    busIn = wdata; ldMDR = wr;
    memEn = 1'b1; rw = wr; memRData = rdata;
    @(posedge clk);
    @(negedge clk);
    ldMAR = 1'b0; ldMDR = 1'b0; memEn = 1'b0;
    for (int t = 0; t <= TO + 5; t++) begin
      if (memReq) begin
        reqc++;
        if (memAddr !== addr || memWe !== wr) bad++;
        if (wr && memWData !== wdata) bad++;
      end
      if (R) begin
        rc++;
        if (rt < 0) rt = t;
      end
      if (ddrStrobe) begin
        dc++;
        dd = ddrData;
      end
      memAck = memReq ? (t == delay) : 1'($urandom_range(1));
      ldMAR = 1'b0; memEn = 1'b0;
      if (poke && t == 0) begin
        marIn = 16'h5555; ldMAR = 1'b1; memEn = 1'b1;
      end
      @(negedge clk);
    end
    memAck = 1'b0;
    checks++;
    if (reqc !== exp_reqc) begin
      errors++;
      $display("FAIL %s req_cycles: got %0d want %0d", nm, reqc, exp_reqc);
    end
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL %s req_signals: got %0d bad cycles want 0", nm, bad);
    end
    checks++;
    if (rc !== 1 || rt !== exp_reqc + 1) begin
      errors++;
      $display("FAIL %s R_pulse: got %0d pulses at %0d want 1 at %0d",
               nm, rc, rt, exp_reqc + 1);
    end
    checks++;
    if (mdrOut !== mdr_m || memAddr !== mar_m) begin
      errors++;
      $display("FAIL %s mdr/mar: got %h/%h want %h/%h",
               nm, mdrOut, memAddr, mdr_m, mar_m);
    end
    checks++;
    if (accErr !== err_m) begin
      errors++;
      $display("FAIL %s accErr: got %b want %b", nm, accErr, err_m);
    end
    checks++;
    if (dc !== exp_dc || (exp_dc == 1 && dd !== wdata[7:0])) begin
      errors++;
      $display("FAIL %s ddr: got %0d pulses data %h want %0d data %h",
               nm, dc, dd, exp_dc, wdata[7:0]);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    checks++;
    if ({R, accErr, memReq, memWe, ddrStrobe} !== 5'b0) begin
      errors++;
      $display("FAIL reset_ctl: got %b want 00000",
               {R, accErr, memReq, memWe, ddrStrobe});
    end
    checks++;
    if (mdrOut !== 16'h0 || memAddr !== 16'h0 || ddrData !== 8'h0) begin
      errors++;
      $display("FAIL reset_data: got %h %h %h want 0 0 0",
               mdrOut, memAddr, ddrData);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_read();
    access("read", 16'h3000, 1'b0, 16'h0, 0, 16'h1234, 1'b0, 16'h0);
  endtask

  task automatic test_write();
    access("write", 16'h4000, 1'b1, 16'hBEEF, 2, 16'h7777, 1'b0, 16'h0);
  endtask

  task automatic test_timeout();
    access("ack_at_limit", 16'h2100, 1'b0, 16'h0, TO - 1, 16'h5A5A,
           1'b0, 16'h0);
    access("timeout", 16'h2200, 1'b0, 16'h0, TO + 2, 16'hFFFF,
           1'b0, 16'h0);
    access("after_timeout", 16'h2300, 1'b0, 16'h0, 1, 16'h0C0C,
           1'b0, 16'h0);
    access("wr_timeout", 16'h2400, 1'b1, 16'h1357, TO, 16'h0,
           1'b0, 16'h0);
  endtask

  task automatic test_busy_ignore();
    access("busy_ignore", 16'h6000, 1'b0, 16'h0, 2, 16'h4321,
           1'b1, 16'h0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 24; i++) begin
      logic [15:0] a;
      a = 16'($urandom);
      if (MMIO && a[15:3] == 13'h1FC0) a[0] = 1'b1;
      access("random", a, 1'($urandom_range(1)), 16'($urandom),
             int'($urandom_range(TO + 1)), 16'($urandom), 1'b0, 16'h0);
    end
  endtask

`ifdef MEM_MMIO_EN
  task automatic test_mmio();
    kbdStrobe = 1'b1; kbdData = 8'h41;
    @(negedge clk);
    kbdStrobe = 1'b0;
    access("kbsr_full", 16'hFE00, 1'b0, 16'h0, 0, 16'h0, 1'b0, 16'h8000);
    access("kbdr", 16'hFE02, 1'b0, 16'h0, 0, 16'h0, 1'b0, 16'h0041);
    access("kbsr_clr", 16'hFE00, 1'b0, 16'h0, 0, 16'h0, 1'b0, 16'h0000);
    access("kbsr_wr", 16'hFE00, 1'b1, 16'hFFFF, 0, 16'h0, 1'b0, 16'h0);
    access("kbsr_ie", 16'hFE00, 1'b0, 16'h0, 0, 16'h0, 1'b0, 16'h4000);
    dspReady = 1'b1;
    access("dsr", 16'hFE04, 1'b0, 16'h0, 0, 16'h0, 1'b0, 16'h8000);
    access("ddr_wr", 16'hFE06, 1'b1, 16'h0058, 0, 16'h0, 1'b0, 16'h0);
  endtask
`else
  task automatic test_no_mmio();
    access("ext_kbsr", 16'hFE00, 1'b0, 16'h0, 1, 16'hCAFE, 1'b0, 16'h0);
    access("ext_ddr", 16'hFE06, 1'b1, 16'h0058, 0, 16'h0, 1'b0, 16'h0);
  endtask
`endif

  task automatic test_reset_mid();
    marIn = 16'h7000; ldMAR = 1'b1; busIn = 16'h9999; ldMDR = 1'b1;
    memEn = 1'b1; rw = 1'b0;
    @(posedge clk);
    @(negedge clk);
    ldMAR = 1'b0; ldMDR = 1'b0; memEn = 1'b0;
    checks++;
    if (memReq !== 1'b1) begin
      errors++;
      $display("FAIL mid_req_up: got %b want 1", memReq);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (memReq !== 1'b0 || R !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_drop: got req %b R %b want 0 0", memReq, R);
    end
    checks++;
    if (memAddr !== 16'h0 || mdrOut !== 16'h0 || accErr !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_regs: got %h %h %b want 0 0 0",
               memAddr, mdrOut, accErr);
    end
    @(negedge clk);
    rst_n = 1'b1;
    mar_m = '0; mdr_m = '0; err_m = 1'b0;
    @(negedge clk);
    checks++;
    if (memReq !== 1'b0 || R !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_idle: got req %b R %b want 0 0", memReq, R);
    end
    access("post_reset", 16'h0123, 1'b0, 16'h0, 0, 16'h0BAD, 1'b0, 16'h0);
  endtask

  initial begin
    test_reset();
    test_read();
    test_write();
    test_timeout();
    test_busy_ignore();
`ifdef MEM_MMIO_EN
    test_mmio();
`else
    test_no_mmio();
`endif
    test_random();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog");
  end

endmodule
